// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard controller
// Purpose: state encoding, register-index type, x0 constant and the load-use match.
// Ports: none (package).
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = 5'd0;

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time; x0 never carries a dependency.
    function automatic logic load_use_hit(
        input logic     mem_read,
        input reg_idx_t rd,
        input reg_idx_t rs1,
        input logic     uses_rs1,
        input reg_idx_t rs2,
        input logic     uses_rs2
    );
        return mem_read && (rd != REG_X0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: performance counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk      in   clock
//   i_clr    in   synchronous clear (active-high)
//   i_inc    in   count enable
//   o_count  out  WIDTH-bit count
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - advance/hold/flush control for the 5-stage pipeline
// Purpose: resolves load-use stalls, taken-branch flushes and data-memory waits,
//          with a watchdog that halts the core when memory never answers.
// Optional feature: HAZARD_PERF_CNT_EN adds StallCycles/FlushCount counters.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   IFID_Rs1/Rs2, IFID_UsesRs1/2 sources read by the ID instruction
//   IDEX_Rd, IDEX_MemRead        destination / load flag of the EX instruction
//   EX_BranchTaken               redirect resolved in EX
//   MEM_Req, MEM_Ready           data-memory request / completion
//   PCWrite, IFID_Write          PC and IF/ID load enables
//   IFID_Flush, IDEX_Flush       bubble insertion into IF/ID and ID/EX
//   EXMEM_Write, MEMWB_Bubble    EX/MEM enable, bubble into MEM/WB
//   MemFault                     sticky watchdog fault
//   StallCycles, FlushCount      saturating perf counters (macro only)
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFID_Rs1,
    input  logic [4:0]       IFID_Rs2,
    input  logic             IFID_UsesRs1,
    input  logic             IFID_UsesRs2,
    input  logic [4:0]       IDEX_Rd,
    input  logic             IDEX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Req,
    input  logic             MEM_Ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Write,
    output logic             MEMWB_Bubble,
    output logic             MemFault
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
`endif
);

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255) || (CNT_W < 1)) begin : g_bad_param
        $error("hazard_control_unit: parameter out of range");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wd_cnt;
    logic [7:0] w_wd_cnt_nxt;
    logic       w_load_use;
    logic       w_freeze;
    logic       w_branch_flush;

    assign w_load_use = load_use_hit(IDEX_MemRead, IDEX_Rd, IFID_Rs1, IFID_UsesRs1,
                                     IFID_Rs2, IFID_UsesRs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_wd_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wd_cnt <= w_wd_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wd_cnt_nxt   = r_wd_cnt;
        PCWrite        = 1'b1;
        IFID_Write     = 1'b1;
        IFID_Flush     = 1'b0;
        IDEX_Flush     = 1'b0;
        EXMEM_Write    = 1'b1;
        MEMWB_Bubble   = 1'b0;
        w_branch_flush = 1'b0;

        // Once in MEM_WAIT only MEM_Ready releases the pipe; the original
        // request is still pending even if MEM_Req is not re-presented.
        case (r_state)
            RUN:      w_freeze = MEM_Req && !MEM_Ready;
            MEM_WAIT: w_freeze = !MEM_Ready;
            default:  w_freeze = 1'b1;
        endcase

        if (rst) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            IFID_Flush   = 1'b1;
            IDEX_Flush   = 1'b1;
            MEMWB_Bubble = 1'b1;
        end else if (w_freeze) begin
            // ID/EX holds (no flush) so a pending branch survives the stall.
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
            case (r_state)
                RUN: begin
                    w_state_nxt  = MEM_WAIT;
                    w_wd_cnt_nxt = 8'd1;
                end
                MEM_WAIT: begin
                    if (r_wd_cnt >= WD_LIMIT) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_wd_cnt_nxt = r_wd_cnt + 8'd1;
                    end
                end
                default: w_state_nxt = HALT;
            endcase
        end else begin
            w_state_nxt  = RUN;
            w_wd_cnt_nxt = '0;
            if (EX_BranchTaken) begin
                // The ID instruction is wrong-path, so its load-use is moot.
                IFID_Flush     = 1'b1;
                IDEX_Flush     = 1'b1;
                w_branch_flush = 1'b1;
            end else if (w_load_use) begin
                PCWrite    = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Flush = 1'b1;
            end
        end
    end

    assign MemFault = (r_state == HALT) && !rst;

`ifdef HAZARD_PERF_CNT_EN
    logic             w_stall_inc;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    assign w_stall_inc = !rst && !PCWrite && (r_state != HALT);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_stall_inc),
        .o_count (w_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_inc   (w_branch_flush),
        .o_count (w_flush_cnt)
    );

    // Registered counts still hold old values during the first reset cycle.
    assign StallCycles = rst ? '0 : w_stall_cnt;
    assign FlushCount  = rst ? '0 : w_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic pcw;
        logic ifidw;
        logic ifidf;
        logic idexf;
        logic exmemw;
        logic memwb;
        logic fault;
    } ctrl_t;

    typedef struct {
        bit         rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        bit         u1;
        bit         u2;
        bit         mr;
        bit         br;
        bit         req;
        bit         rdy;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] IFID_Rs1 = '0, IFID_Rs2 = '0, IDEX_Rd = '0;
    logic       IFID_UsesRs1 = 0, IFID_UsesRs2 = 0, IDEX_MemRead = 0;
    logic       EX_BranchTaken = 0, MEM_Req = 0, MEM_Ready = 0;
    logic       PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Bubble, MemFault;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] StallCycles, FlushCount;
    logic [CNT_W-1:0] exp_stall_q[$];
    logic [CNT_W-1:0] exp_flush_q[$];
`endif

    always #5 clk = ~clk;

    hazard_control_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IFID_Rs1(IFID_Rs1), .IFID_Rs2(IFID_Rs2),
        .IFID_UsesRs1(IFID_UsesRs1), .IFID_UsesRs2(IFID_UsesRs2),
        .IDEX_Rd(IDEX_Rd), .IDEX_MemRead(IDEX_MemRead),
        .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Flush(IDEX_Flush), .EXMEM_Write(EXMEM_Write),
        .MEMWB_Bubble(MEMWB_Bubble), .MemFault(MemFault)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
    );

    ctrl_t exp_q[$];
    int    tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    // Reference state: halted flag, memory-wait cycles consumed so far
    // (0 = not waiting), and event tallies for the perf counters.
    bit     m_halted = 0;
    int     m_waited = 0;
    longint m_stall  = 0;
    longint m_flush  = 0;

    function automatic longint sat(input longint v);
        longint lim = (longint'(1) << CNT_W) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_cycle(input stim_t s);
        ctrl_t e;
        bit    hazard, frozen;
        hazard = s.mr && (s.rd != 0) &&
                 ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
`ifdef HAZARD_PERF_CNT_EN
        exp_stall_q.push_back(s.rst ? '0 : CNT_W'(sat(m_stall)));
        exp_flush_q.push_back(s.rst ? '0 : CNT_W'(sat(m_flush)));
`endif
        if (s.rst) begin
            e = '{pcw:0, ifidw:0, ifidf:1, idexf:1, exmemw:0, memwb:1, fault:0};
            m_halted = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        end else if (m_halted) begin
            e = '{pcw:0, ifidw:0, ifidf:0, idexf:0, exmemw:0, memwb:1, fault:1};
        end else begin
            frozen = (m_waited > 0) ? !s.rdy : (s.req && !s.rdy);
            if (frozen) begin
                e = '{pcw:0, ifidw:0, ifidf:0, idexf:0, exmemw:0, memwb:1, fault:0};
                m_stall++;
                if (m_waited == 0)      m_waited = 1;
                else if (m_waited >= TO) begin m_halted = 1; m_waited = 0; end
                else                    m_waited++;
            end else begin
                m_waited = 0;
                if (s.br) begin
                    e = '{pcw:1, ifidw:1, ifidf:1, idexf:1, exmemw:1, memwb:0, fault:0};
                    m_flush++;
                end else if (hazard) begin
                    e = '{pcw:0, ifidw:0, ifidf:0, idexf:1, exmemw:1, memwb:0, fault:0};
                    m_stall++;
                end else begin
                    e = '{pcw:1, ifidw:1, ifidf:0, idexf:0, exmemw:1, memwb:0, fault:0};
                end
            end
        end
        exp_q.push_back(e);
        tag_q.push_back(cyc);
    endtask

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        cyc++;
        rst = s.rst; IFID_Rs1 = s.rs1; IFID_Rs2 = s.rs2; IDEX_Rd = s.rd;
        IFID_UsesRs1 = s.u1; IFID_UsesRs2 = s.u2; IDEX_MemRead = s.mr;
        EX_BranchTaken = s.br; MEM_Req = s.req; MEM_Ready = s.rdy;
        model_cycle(s);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst:0, rs1:0, rs2:0, rd:0, u1:0, u2:0, mr:0, br:0, req:0, rdy:0};
        return s;
    endfunction

    // Monitor: outputs are valid every cycle, so compare one entry per cycle.
    initial begin
        ctrl_t e, a;
        int    t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = '{pcw:PCWrite, ifidw:IFID_Write, ifidf:IFID_Flush, idexf:IDEX_Flush,
                      exmemw:EXMEM_Write, memwb:MEMWB_Bubble, fault:MemFault};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL ctrl cycle %0d: got %b want %b (pcw,ifidw,ifidf,idexf,exmemw,memwb,fault)",
                             t, a, e);
                end
`ifdef HAZARD_PERF_CNT_EN
                begin
                    logic [CNT_W-1:0] es, ef;
                    es = exp_stall_q.pop_front();
                    ef = exp_flush_q.pop_front();
                    n_tests++;
                    if (StallCycles !== es) begin
                        n_fail++;
                        $display("FAIL stall_cnt cycle %0d: got %0d want %0d", t, StallCycles, es);
                    end
                    n_tests++;
                    if (FlushCount !== ef) begin
                        n_fail++;
                        $display("FAIL flush_cnt cycle %0d: got %0d want %0d", t, FlushCount, ef);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1;
        repeat (2) drive(s);

        // load-use, then the bubble cycle, then rd = x0 (no stall)
        s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; drive(s);
        s = idle(); s.rs1 = 5; s.u1 = 1; drive(s);
        s = idle(); s.mr = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1; drive(s);
        s = idle(); s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1; drive(s);
        s = idle(); drive(s);

        // load-use together with a taken branch
        s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; s.br = 1; drive(s);
        s = idle(); drive(s);

        // memory stall of 3 cycles, release on the 4th
        s = idle(); s.req = 1;
        repeat (3) drive(s);
        s.rdy = 1; drive(s);
        s = idle(); drive(s);

        // branch behind a 2-cycle stall
        s = idle(); s.req = 1; s.br = 1;
        repeat (2) drive(s);
        s.rdy = 1; drive(s);
        s = idle(); drive(s);

        // never-ready memory: fault, sticky, cleared by reset
        s = idle(); s.req = 1;
        repeat (TO + 1) drive(s);
        s.rdy = 1; repeat (2) drive(s);
        s = idle(); s.rst = 1; drive(s);
        s = idle(); drive(s);

        // ready arrives exactly at the limit: release without fault
        s = idle(); s.req = 1;
        repeat (TO) drive(s);
        s.rdy = 1; drive(s);
        s = idle(); repeat (2) drive(s);

        // reset asserted mid-stall
        s = idle(); s.req = 1;
        repeat (2) drive(s);
        s = idle(); s.rst = 1; drive(s);
        s = idle(); s.rdy = 0; drive(s);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.u1  = $urandom_range(0, 1);
            s.u2  = $urandom_range(0, 1);
            s.mr  = $urandom_range(0, 1);
            s.br  = ($urandom_range(0, 3) == 0);
            s.req = ($urandom_range(0, 4) < 2);
            s.rdy = $urandom_range(0, 1);
            drive(s);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
